ic_service_master: RTL and testbench

//  Processor-side agent for the priority interrupt controller. Acts as the APB-style initiator that programs
//  the controller's per-interrupt priority registers from a simple host request port. Also acts as the

---
 rtl/ic_pkg.sv | 37 +++
 rtl/ic_apb_initiator.sv | 161 ++++++++++++++++
 rtl/ic_service_master.sv | 189 ++++++++++++++++++
 tb/tb_ic_service_master.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared definitions for the interrupt-controller service master: sizes, FSM
// encodings and saturating-increment helpers.
package ic_pkg;

  localparam int NUM_INTR       = 16;
  localparam int ID_W           = 4;
  localparam int DATA_W         = 8;
  localparam int SVC_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

  localparam logic [7:0]  ADDR_LIMIT  = 8'(NUM_INTR);
  localparam logic [15:0] SVC_CNT_MAX = 16'hFFFF;
  localparam logic [7:0]  HIST_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_SETUP  = 2'd1,
    A_ACCESS = 2'd2,
    A_DONE   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVICE = 2'd1,
    S_ACK     = 2'd2,
    S_DRAIN   = 2'd3
  } svc_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == SVC_CNT_MAX) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == HIST_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ic_apb_initiator.sv
// APB-style initiator: turns a held host request into one setup/access bus
// cycle with a pready timeout, and returns a one-cycle ack with data/error.
module ic_apb_initiator
  import ic_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              cfg_req_i,
  input  logic              cfg_wr_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  output logic              cfg_ack_o,
  output logic [DATA_W-1:0] cfg_rdata_o,
  output logic              cfg_err_o,
  output logic [7:0]        paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic              pwrite_o,
  output logic              penable_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              perror_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  apb_state_e        state_r, state_nxt_s;
  logic [7:0]        tmo_r, tmo_nxt_s;
  logic              err_r, err_nxt_s;
  logic [7:0]        paddr_r, paddr_nxt_s;
  logic [DATA_W-1:0] pwdata_r, pwdata_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
  logic              pwrite_r, pwrite_nxt_s;
  logic              penable_r, penable_nxt_s;
  logic              ack_r, ack_nxt_s;
  logic              cfg_err_r, cfg_err_nxt_s;
  logic              accept_s;
  logic              addr_ok_s;

  // The ack cycle itself still sees the held request, so it must not be re-accepted.
  assign accept_s  = cfg_req_i & ~ack_r;
  assign addr_ok_s = (cfg_addr_i < ADDR_LIMIT);

  // State and registered outputs; reset drops any in-flight transfer.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      state_r   <= A_IDLE;
      tmo_r     <= 8'd0;
      err_r     <= 1'b0;
      paddr_r   <= 8'd0;
      pwdata_r  <= '0;
      rdata_r   <= '0;
      pwrite_r  <= 1'b0;
      penable_r <= 1'b0;
      ack_r     <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_r     <= tmo_nxt_s;
      err_r     <= err_nxt_s;
      paddr_r   <= paddr_nxt_s;
      pwdata_r  <= pwdata_nxt_s;
      rdata_r   <= rdata_nxt_s;
      pwrite_r  <= pwrite_nxt_s;
      penable_r <= penable_nxt_s;
      ack_r     <= ack_nxt_s;
      cfg_err_r <= cfg_err_nxt_s;
    end
  end

  // Bus FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      A_IDLE: begin
        if (accept_s && addr_ok_s) begin
          state_nxt_s = A_SETUP;
        end else if (accept_s) begin
          state_nxt_s = A_DONE;
        end else begin
          state_nxt_s = A_IDLE;
        end
      end
      A_SETUP:  state_nxt_s = A_ACCESS;
      A_ACCESS: begin
        if (pready_i || (tmo_r >= TMO_LAST)) begin
          state_nxt_s = A_DONE;
        end else begin
          state_nxt_s = A_ACCESS;
        end
      end
      A_DONE:   state_nxt_s = A_IDLE;
      default:  state_nxt_s = A_IDLE;
    endcase
  end

  // Bus FSM output decode; every output register gets its next value here.
  always_comb begin
    paddr_nxt_s   = paddr_r;
    pwdata_nxt_s  = pwdata_r;
    pwrite_nxt_s  = pwrite_r;
    penable_nxt_s = penable_r;
    rdata_nxt_s   = rdata_r;
    tmo_nxt_s     = tmo_r;
    err_nxt_s     = err_r;
    ack_nxt_s     = 1'b0;
    cfg_err_nxt_s = 1'b0;
    case (state_r)
      A_IDLE: begin
        if (accept_s && addr_ok_s) begin
          paddr_nxt_s   = cfg_addr_i;
          pwdata_nxt_s  = cfg_wdata_i;
          pwrite_nxt_s  = cfg_wr_i;
          penable_nxt_s = 1'b0;
          err_nxt_s     = 1'b0;
        end else if (accept_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      A_SETUP: begin
        penable_nxt_s = 1'b1;
        tmo_nxt_s     = 8'd0;
      end
      A_ACCESS: begin
        if (pready_i) begin
          penable_nxt_s = 1'b0;
          err_nxt_s     = perror_i;
          if (!pwrite_r) begin
            rdata_nxt_s = prdata_i;
          end else begin
            rdata_nxt_s = rdata_r;
          end
        end else if (tmo_r >= TMO_LAST) begin
          penable_nxt_s = 1'b0;
          err_nxt_s     = 1'b1;
        end else begin
          tmo_nxt_s = tmo_r + 8'd1;
        end
      end
      A_DONE: begin
        ack_nxt_s     = 1'b1;
        cfg_err_nxt_s = err_r;
      end
      default: begin
        penable_nxt_s = 1'b0;
      end
    endcase
  end

  assign cfg_ack_o   = ack_r;
  assign cfg_rdata_o = rdata_r;
  assign cfg_err_o   = cfg_err_r;
  assign paddr_o     = paddr_r;
  assign pwdata_o    = pwdata_r;
  assign pwrite_o    = pwrite_r;
  assign penable_o   = penable_r;

endmodule

// File: rtl/ic_service_master.sv
// Processor-side agent for the priority interrupt controller: bus initiator for
// priority registers plus the interrupt servicing handshake. IC_SVC_HIST_EN adds a per-ID histogram.
module ic_service_master
  import ic_pkg::*;
#(
  parameter int SVC_CYCLES = SVC_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  input  logic              cfg_req_i,
  input  logic              cfg_wr_i,
  input  logic [7:0]        cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_wdata_i,
  output logic              cfg_ack_o,
  output logic [DATA_W-1:0] cfg_rdata_o,
  output logic              cfg_err_o,
  output logic [7:0]        paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  output logic              pwrite_o,
  output logic              penable_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              perror_i,
  input  logic              intr_valid_i,
  input  logic [ID_W-1:0]   intr_to_service_i,
  output logic              intr_serviced_o,
  output logic              svc_busy_o,
  output logic [ID_W-1:0]   svc_id_o,
  output logic [15:0]       svc_count_o
`ifdef IC_SVC_HIST_EN
  ,
  input  logic [ID_W-1:0]   hist_sel_i,
  output logic [7:0]        hist_cnt_o
`endif
);

  localparam logic [7:0] SVC_LOAD = 8'(SVC_CYCLES);

  svc_state_e      svc_state_r, svc_state_nxt_s;
  logic [7:0]      cnt_r, cnt_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic [ID_W-1:0] id_r, id_nxt_s;
  logic            serviced_r, serviced_nxt_s;
  logic [15:0]     count_r, count_nxt_s;

  ic_apb_initiator #(
    .TIMEOUT (TIMEOUT)
  ) u_apb (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .cfg_req_i   (cfg_req_i),
    .cfg_wr_i    (cfg_wr_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_ack_o   (cfg_ack_o),
    .cfg_rdata_o (cfg_rdata_o),
    .cfg_err_o   (cfg_err_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pwrite_o    (pwrite_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .perror_i    (perror_i)
  );

  // Service FSM state and registered outputs.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      svc_state_r <= S_IDLE;
      cnt_r       <= 8'd0;
      busy_r      <= 1'b0;
      id_r        <= '0;
      serviced_r  <= 1'b0;
      count_r     <= 16'd0;
    end else begin
      svc_state_r <= svc_state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      id_r        <= id_nxt_s;
      serviced_r  <= serviced_nxt_s;
      count_r     <= count_nxt_s;
    end
  end

  // Service FSM next-state decode; a dropped valid aborts without completing.
  always_comb begin
    svc_state_nxt_s = svc_state_r;
    case (svc_state_r)
      S_IDLE: begin
        if (intr_valid_i) begin
          svc_state_nxt_s = S_SERVICE;
        end else begin
          svc_state_nxt_s = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (!intr_valid_i) begin
          svc_state_nxt_s = S_IDLE;
        end else if (cnt_r <= 8'd1) begin
          svc_state_nxt_s = S_ACK;
        end else begin
          svc_state_nxt_s = S_SERVICE;
        end
      end
      S_ACK:   svc_state_nxt_s = S_DRAIN;
      S_DRAIN: begin
        if (!intr_valid_i) begin
          svc_state_nxt_s = S_IDLE;
        end else begin
          svc_state_nxt_s = S_DRAIN;
        end
      end
      default: svc_state_nxt_s = S_IDLE;
    endcase
  end

  // Service FSM output decode; pulse and count land together on entry to S_ACK.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    busy_nxt_s     = busy_r;
    id_nxt_s       = id_r;
    serviced_nxt_s = 1'b0;
    count_nxt_s    = count_r;
    case (svc_state_r)
      S_IDLE: begin
        if (intr_valid_i) begin
          id_nxt_s   = intr_to_service_i;
          busy_nxt_s = 1'b1;
          cnt_nxt_s  = SVC_LOAD;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      S_SERVICE: begin
        if (!intr_valid_i) begin
          busy_nxt_s = 1'b0;
          cnt_nxt_s  = 8'd0;
        end else if (cnt_r <= 8'd1) begin
          serviced_nxt_s = 1'b1;
          count_nxt_s    = sat_inc16(count_r);
          cnt_nxt_s      = 8'd0;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      S_ACK: begin
        busy_nxt_s = 1'b1;
      end
      S_DRAIN: begin
        if (!intr_valid_i) begin
          busy_nxt_s = 1'b0;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        busy_nxt_s = 1'b0;
        cnt_nxt_s  = 8'd0;
      end
    endcase
  end

  assign intr_serviced_o = serviced_r;
  assign svc_busy_o      = busy_r;
  assign svc_id_o        = id_r;
  assign svc_count_o     = count_r;

`ifdef IC_SVC_HIST_EN
  logic [7:0] hist_r [NUM_INTR];

  // Per-ID service histogram, bumped in step with the serviced pulse.
  always_ff @(posedge pclk_i) begin
    for (int i = 0; i < NUM_INTR; i++) begin
      if (!prst_i) begin
        hist_r[i] <= 8'd0;
      end else if (serviced_nxt_s && (id_r == ID_W'(i))) begin
        hist_r[i] <= sat_inc8(hist_r[i]);
      end else begin
        hist_r[i] <= hist_r[i];
      end
    end
  end

  assign hist_cnt_o = hist_r[hist_sel_i];
`endif

endmodule

// File: tb/tb_ic_service_master.sv
// Self-checking bench for ic_service_master: models the priority-register bus
// target and the interrupt source, and checks against a high-level reference.
module tb_ic_service_master;
  import ic_pkg::*;

  localparam int SVC = SVC_CYCLES_DEF;
  localparam int TMO = TIMEOUT_DEF;

  logic              pclk_i = 1'b0;
  logic              prst_i = 1'b0;
  logic              cfg_req_i = 1'b0;
  logic              cfg_wr_i = 1'b0;
  logic [7:0]        cfg_addr_i = 8'd0;
  logic [DATA_W-1:0] cfg_wdata_i = '0;
  logic              cfg_ack_o;
  logic [DATA_W-1:0] cfg_rdata_o;
  logic              cfg_err_o;
  logic [7:0]        paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pwrite_o;
  logic              penable_o;
  logic [DATA_W-1:0] prdata_i = '0;
  logic              pready_i = 1'b0;
  logic              perror_i = 1'b0;
  logic              intr_valid_i = 1'b0;
  logic [ID_W-1:0]   intr_to_service_i = '0;
  logic              intr_serviced_o;
  logic              svc_busy_o;
  logic [ID_W-1:0]   svc_id_o;
  logic [15:0]       svc_count_o;
`ifdef IC_SVC_HIST_EN
  logic [ID_W-1:0]   hist_sel_i = '0;
  logic [7:0]        hist_cnt_o;
`endif

  always #5 pclk_i = ~pclk_i;

  ic_service_master dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .cfg_req_i         (cfg_req_i),
    .cfg_wr_i          (cfg_wr_i),
    .cfg_addr_i        (cfg_addr_i),
    .cfg_wdata_i       (cfg_wdata_i),
    .cfg_ack_o         (cfg_ack_o),
    .cfg_rdata_o       (cfg_rdata_o),
    .cfg_err_o         (cfg_err_o),
    .paddr_o           (paddr_o),
    .pwdata_o          (pwdata_o),
    .pwrite_o          (pwrite_o),
    .penable_o         (penable_o),
    .prdata_i          (prdata_i),
    .pready_i          (pready_i),
    .perror_i          (perror_i),
    .intr_valid_i      (intr_valid_i),
    .intr_to_service_i (intr_to_service_i),
    .intr_serviced_o   (intr_serviced_o),
    .svc_busy_o        (svc_busy_o),
    .svc_id_o          (svc_id_o),
    .svc_count_o       (svc_count_o)
`ifdef IC_SVC_HIST_EN
    ,
    .hist_sel_i        (hist_sel_i),
    .hist_cnt_o        (hist_cnt_o)
`endif
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         pulse_cnt = 0;
  int         slave_wait = 0;
  logic       slave_err = 1'b0;
  int         wait_cnt = 0;
  logic [7:0] slave_mem [NUM_INTR];
  logic [7:0] ref_prio [NUM_INTR];
  logic [7:0] last_rd = 8'd0;
  int         ref_svc = 0;
  int         ref_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus target: pready after slave_wait extra access cycles; errored writes are not stored.
  initial begin
    forever begin
      @(negedge pclk_i);
      if (penable_o && (wait_cnt == slave_wait)) begin
        pready_i = 1'b1;
        prdata_i = slave_mem[paddr_o[3:0]];
        perror_i = slave_err;
        if (pwrite_o && !slave_err) slave_mem[paddr_o[3:0]] = pwdata_o;
        wait_cnt = 0;
      end else if (penable_o) begin
        pready_i = 1'b0;
        prdata_i = 8'($urandom);
        perror_i = 1'($urandom);
        wait_cnt++;
      end else begin
        pready_i = 1'b0;
        prdata_i = 8'($urandom);
        perror_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Counts every cycle intr_serviced_o is high, so stretched pulses show up.
  initial begin
    forever begin
      @(negedge pclk_i);
      if (intr_serviced_o === 1'b1) pulse_cnt++;
    end
  end

  task automatic cfg_op(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input int wt, input logic einj, output int lat, output logic [7:0] rd,
                        output logic er, output logic pen, output logic xack);
    logic done;
    @(negedge pclk_i);
    slave_wait  = wt;
    slave_err   = einj;
    cfg_req_i   = 1'b1;
    cfg_wr_i    = wr;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    lat = 0; rd = 8'd0; er = 1'b0; pen = 1'b0; xack = 1'b0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge pclk_i); #1;
      lat++;
      if (penable_o) pen = 1'b1;
      if (cfg_ack_o) begin
        done = 1'b1;
        rd   = cfg_rdata_o;
        er   = cfg_err_o;
      end
    end
    // Host releases the request only after the edge that closes the ack cycle.
    @(posedge pclk_i); #1;
    cfg_req_i = 1'b0;
    if (cfg_ack_o) xack = 1'b1;
    repeat (8) begin
      @(posedge pclk_i); #1;
      if (cfg_ack_o) xack = 1'b1;
    end
  endtask

  task automatic svc_op(input logic [ID_W-1:0] id, input int abort_at, output int lat,
                        output logic [ID_W-1:0] sid, output logic [15:0] cnt, output logic busy_after);
    logic seen;
    @(negedge pclk_i);
    intr_valid_i      = 1'b1;
    intr_to_service_i = id;
    lat = 0; seen = 1'b0; sid = '0; cnt = 16'd0;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge pclk_i);
      @(negedge pclk_i);
      intr_valid_i = 1'b0;
      @(posedge pclk_i); #1;
      busy_after = svc_busy_o;
      repeat (6) @(posedge pclk_i);
      #1;
      cnt = svc_count_o;
    end else begin
      while (!seen && lat < 20) begin
        @(posedge pclk_i); #1;
        lat++;
        if (intr_serviced_o) begin
          seen = 1'b1;
          sid  = svc_id_o;
          cnt  = svc_count_o;
        end
      end
      @(negedge pclk_i);
      intr_valid_i = 1'b0;
      repeat (2) @(posedge pclk_i);
      #1;
      busy_after = svc_busy_o;
    end
  endtask

  task automatic svc_check(input string tag, input logic [ID_W-1:0] id, input int abort_at);
    int lat;
    logic [ID_W-1:0] sid;
    logic [15:0] cnt;
    logic busy_after;
    svc_op(id, abort_at, lat, sid, cnt, busy_after);
    if (abort_at == 0) begin
      if (ref_svc < 65535) ref_svc++;
      ref_pulses++;
      chk({tag, "_lat"}, lat, SVC + 1);
      chk({tag, "_id"}, sid, id);
    end else begin
      chk({tag, "_abort_count"}, cnt, ref_svc);
    end
    chk({tag, "_count"}, svc_count_o, ref_svc);
    chk({tag, "_busy_after"}, busy_after, 1'b0);
    chk({tag, "_pulses"}, pulse_cnt, ref_pulses);
  endtask

  task automatic cfg_check(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, input int wt, input logic einj);
    int lat;
    logic [7:0] rd, exp_rd;
    logic er, pen, xack, good;
    cfg_op(wr, addr, data, wt, einj, lat, rd, er, pen, xack);
    good = (addr < 8'(NUM_INTR));
    exp_rd = (good && !wr) ? ref_prio[addr[3:0]] : last_rd;
    chk({tag, "_lat"}, lat, good ? (4 + wt) : 2);
    chk({tag, "_err"}, er, good ? einj : 1'b1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_bus_cycle"}, pen, good);
    chk({tag, "_single_ack"}, xack, 1'b0);
    if (good && wr && !einj) ref_prio[addr[3:0]] = data;
    last_rd = exp_rd;
  endtask

  initial begin
    int lat;
    logic [7:0] rd, v;
    logic er, pen, xack;

    for (int i = 0; i < NUM_INTR; i++) begin
      v = 8'($urandom);
      slave_mem[i] = v;
      ref_prio[i]  = v;
    end

    // Reset state.
    repeat (3) @(posedge pclk_i);
    #1;
    chk("reset_bus", {cfg_ack_o, cfg_err_o, cfg_rdata_o, paddr_o, pwdata_o, pwrite_o, penable_o}, 32'd0);
    chk("reset_svc", {intr_serviced_o, svc_busy_o, svc_id_o, svc_count_o}, 32'd0);
    @(negedge pclk_i);
    prst_i = 1'b1;

    // Write then read back priority 3.
    cfg_check("wr3", 1'b1, 8'd3, 8'h5A, 0, 1'b0);
    cfg_check("rd3", 1'b0, 8'd3, 8'h00, 0, 1'b0);
    chk("rd3_value", last_rd, 8'h5A);

    // Out-of-range address: no bus cycle, early error ack.
    cfg_check("bad16", 1'b1, 8'd16, 8'hA5, 0, 1'b0);

    // Bus never ready: timeout abort.
    cfg_op(1'b1, 8'd7, 8'h33, 99, 1'b0, lat, rd, er, pen, xack);
    chk("tmo_lat", lat, 4 + TMO - 1);
    chk("tmo_err", er, 1'b1);
    chk("tmo_penable_after", penable_o, 1'b0);
    chk("tmo_rdata_hold", rd, last_rd);

    // Two services in sequence.
    svc_check("svc9", 4'd9, 0);
    svc_check("svc2", 4'd2, 0);
    chk("svc_total", svc_count_o, 16'd2);

    // Early valid drop aborts without a pulse.
    svc_check("abort3", 4'd6, 3);

    // Config write while a service is running.
    @(negedge pclk_i);
    intr_valid_i      = 1'b1;
    intr_to_service_i = 4'd11;
    cfg_op(1'b1, 8'd6, 8'hC7, 1, 1'b0, lat, rd, er, pen, xack);
    ref_prio[6] = 8'hC7;
    for (int i = 0; i < 10 && pulse_cnt == ref_pulses; i++) @(posedge pclk_i);
    @(negedge pclk_i);
    intr_valid_i = 1'b0;
    repeat (2) @(posedge pclk_i);
    #1;
    ref_svc++;
    ref_pulses++;
    chk("conc_cfg_lat", lat, 5);
    chk("conc_cfg_err", er, 1'b0);
    chk("conc_pulses", pulse_cnt, ref_pulses);
    chk("conc_count", svc_count_o, ref_svc);
    chk("conc_id", svc_id_o, 4'd11);
    cfg_check("conc_rd6", 1'b0, 8'd6, 8'h00, 2, 1'b0);

    // Randomized config traffic.
    for (int k = 0; k < 24; k++) begin
      cfg_check("rnd_cfg", 1'($urandom), 8'($urandom_range(0, 17)), 8'($urandom),
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // Randomized services, some aborted.
    for (int k = 0; k < 12; k++) begin
      svc_check("rnd_svc", 4'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, SVC) : 0);
    end

    // Reset while both FSMs are mid-operation.
    @(negedge pclk_i);
    intr_valid_i      = 1'b1;
    intr_to_service_i = 4'd7;
    slave_wait        = 99;
    cfg_req_i         = 1'b1;
    cfg_wr_i          = 1'b1;
    cfg_addr_i        = 8'd4;
    cfg_wdata_i       = 8'hC3;
    repeat (3) @(posedge pclk_i);
    #1;
    chk("midop_penable", penable_o, 1'b1);
    chk("midop_busy", svc_busy_o, 1'b1);
    @(negedge pclk_i);
    prst_i       = 1'b0;
    cfg_req_i    = 1'b0;
    intr_valid_i = 1'b0;
    @(posedge pclk_i); #1;
    chk("midop_reset_bus", {cfg_ack_o, cfg_err_o, cfg_rdata_o, paddr_o, pwdata_o, pwrite_o, penable_o}, 32'd0);
    chk("midop_reset_svc", {intr_serviced_o, svc_busy_o, svc_id_o, svc_count_o}, 32'd0);
    @(negedge pclk_i);
    prst_i = 1'b1;
    ref_svc = 0;
    last_rd = 8'd0;
    repeat (8) @(posedge pclk_i);
    #1;
    chk("midop_no_pulse", pulse_cnt, ref_pulses);
    chk("midop_count", svc_count_o, 16'd0);
    chk("midop_idle", {svc_busy_o, penable_o, cfg_ack_o}, 3'd0);

`ifdef IC_SVC_HIST_EN
    for (int k = 0; k < 3; k++) svc_check("hist5", 4'd5, 0);
    for (int i = 0; i < NUM_INTR; i++) begin
      @(negedge pclk_i);
      hist_sel_i = ID_W'(i);
      #1;
      chk("hist_after3", hist_cnt_o, (i == 5) ? 8'd3 : 8'd0);
    end
    for (int k = 0; k < 297; k++) svc_check("hist5_sat", 4'd5, 0);
    @(negedge pclk_i);
    hist_sel_i = 4'd5;
    #1;
    chk("hist_saturated", hist_cnt_o, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
